// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: ID-stage decode info, EX-stage register info, memory wait and
// the pipeline control outputs.
// Modports:
//   master - pipeline side: drives the ID/EX status and mem_busy, observes the controls
//   slave  - hazard_ctrl side: observes the status, drives the controls
// Optional HAZARD_PERF_CNT_EN adds the stall_cycles / flush_count performance counters.
interface hazard_ctrl_if
`ifdef HAZARD_PERF_CNT_EN
  #(parameter int unsigned PERF_W = 32)
`endif
  ;
  logic [31:0] instruction_ID;
  logic        branch_ID;
  logic        branch_taken_ID;
  logic        jump_ID;
  logic        ID_EX_MemRead;
  logic        ID_EX_RegWrite;
  logic [4:0]  ID_EX_wreg;
  logic        mem_busy;
  logic        PC_write;
  logic        IF_ID_write;
  logic        IF_Flush;
  logic        ID_EX_bubble;
  logic        pipe_freeze;
  logic        timeout_err;
`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cycles;
  logic [PERF_W-1:0] flush_count;
`endif

  modport master (
    output instruction_ID, branch_ID, branch_taken_ID, jump_ID,
    output ID_EX_MemRead, ID_EX_RegWrite, ID_EX_wreg, mem_busy,
    input  PC_write, IF_ID_write, IF_Flush, ID_EX_bubble, pipe_freeze, timeout_err
`ifdef HAZARD_PERF_CNT_EN
    , input stall_cycles, flush_count
`endif
  );

  modport slave (
    input  instruction_ID, branch_ID, branch_taken_ID, jump_ID,
    input  ID_EX_MemRead, ID_EX_RegWrite, ID_EX_wreg, mem_busy,
    output PC_write, IF_ID_write, IF_Flush, ID_EX_bubble, pipe_freeze, timeout_err
`ifdef HAZARD_PERF_CNT_EN
    , output stall_cycles, flush_count
`endif
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller. Produces PC_write, IF_ID_write, IF_Flush, ID_EX_bubble and
// pipe_freeze from load-use / branch-operand hazard detection in ID, a multi-cycle stall
// FSM and a data-memory wait freeze with a sticky watchdog (timeout_err).
// Ports:
//   clk   - pipeline clock, all state on rising edge
//   rst_n - asynchronous active-low reset; outputs forced to the IF/ID-clearing pattern
//   hz    - hazard_ctrl_if.slave bundle (ID/EX status in, pipeline controls out)
// Build option: define HAZARD_PERF_CNT_EN to add the stall_cycles and flush_count counters.
module hazard_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_W           = 8
`ifdef HAZARD_PERF_CNT_EN
  , parameter int unsigned PERF_W       = 32
`endif
) (
  input logic          clk,
  input logic          rst_n,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {StRun, StStall, StFreeze} state_e;

  localparam logic [TO_W-1:0] ToLimit = TO_W'(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] ToMax   = '1;

  state_e          state_q, state_d, eff_state;
  logic [1:0]      stall_left_q, stall_left_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_q, err_d;

  logic [4:0] rs, rt;
  logic       wreg_hit, lu, bh, hazard, need_two;
  logic       pc_write, if_id_write, if_flush, bubble, freeze;

  logic unused_instr;
  assign unused_instr = ^{hz.instruction_ID[31:26], hz.instruction_ID[15:0]};

  assign rs       = hz.instruction_ID[25:21];
  assign rt       = hz.instruction_ID[20:16];
  assign wreg_hit = (hz.ID_EX_wreg != 5'd0) &&
                    ((hz.ID_EX_wreg == rs) || (hz.ID_EX_wreg == rt));
  assign lu       = hz.ID_EX_MemRead & wreg_hit;
  assign bh       = hz.branch_ID & hz.ID_EX_RegWrite & ~hz.ID_EX_MemRead & wreg_hit;
  assign hazard   = lu | bh;
  assign need_two = lu & hz.branch_ID;

  always_comb begin
    state_d      = state_q;
    stall_left_d = stall_left_q;
    to_cnt_d     = '0;
    err_d        = err_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_flush     = 1'b0;
    bubble       = 1'b0;
    freeze       = 1'b0;

    // Leaving FREEZE applies the resumed state's rules in the same cycle; the saved
    // return state is implied by whether a stall was still pending.
    eff_state = state_q;
    if (state_q == StFreeze) begin
      eff_state = (stall_left_q != 2'd0) ? StStall : StRun;
    end

    if (hz.mem_busy) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      freeze      = 1'b1;
      state_d     = StFreeze;
      to_cnt_d    = (to_cnt_q == ToMax) ? to_cnt_q : to_cnt_q + 1'b1;
      if (to_cnt_d == ToLimit) begin
        err_d = 1'b1;
      end
    end else begin
      unique case (eff_state)
        StStall: begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          bubble       = 1'b1;
          stall_left_d = stall_left_q - 2'd1;
          state_d      = (stall_left_d == 2'd0) ? StRun : StStall;
        end
        default: begin
          state_d = StRun;
          if (hazard) begin
            // This cycle is the first bubble; a second one is sequenced via STALL.
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            bubble      = 1'b1;
            if (need_two) begin
              stall_left_d = 2'd1;
              state_d      = StStall;
            end
          end else begin
            if_flush = (hz.branch_ID & hz.branch_taken_ID) | hz.jump_ID;
          end
        end
      endcase
    end

    // Clear IF/ID if the clock keeps running while reset is held.
    if (!rst_n) begin
      pc_write    = 1'b0;
      if_id_write = 1'b1;
      if_flush    = 1'b1;
      bubble      = 1'b1;
      freeze      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StRun;
      stall_left_q <= 2'd0;
      to_cnt_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      stall_left_q <= stall_left_d;
      to_cnt_q     <= to_cnt_d;
      err_q        <= err_d;
    end
  end

  assign hz.PC_write     = pc_write;
  assign hz.IF_ID_write  = if_id_write;
  assign hz.IF_Flush     = if_flush;
  assign hz.ID_EX_bubble = bubble;
  assign hz.pipe_freeze  = freeze;
  assign hz.timeout_err  = err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cycles_q, flush_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (bubble | freeze) stall_cycles_q <= stall_cycles_q + 1'b1;
      if (if_flush)        flush_count_q  <= flush_count_q + 1'b1;
    end
  end

  assign hz.stall_cycles = stall_cycles_q;
  assign hz.flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
`timescale 1ns/1ps
module tb_hazard_ctrl;
  localparam int unsigned TO = 5;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  hazard_ctrl_if hif ();

  hazard_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference model: pending bubble count, freeze length, sticky error.
  int m_pending = 0, n_pending = 0;
  int m_frz     = 0, n_frz     = 0;
  bit m_err     = 0, n_err     = 0;
`ifdef HAZARD_PERF_CNT_EN
  int unsigned m_stall = 0, n_stall = 0, m_flush = 0, n_flush = 0;
`endif

  always @(negedge clk) begin
    logic [4:0] rs, rt, w;
    bit hit, lu, bh;
    int need;
    bit e_pc, e_ifid, e_fl, e_bub, e_frz;
    rs   = hif.instruction_ID[25:21];
    rt   = hif.instruction_ID[20:16];
    w    = hif.ID_EX_wreg;
    hit  = (w != 0) && (w == rs || w == rt);
    lu   = hif.ID_EX_MemRead && hit;
    bh   = hif.branch_ID && hif.ID_EX_RegWrite && !hif.ID_EX_MemRead && hit;
    need = lu ? (hif.branch_ID ? 2 : 1) : (bh ? 1 : 0);
    n_pending = m_pending;
    n_frz     = 0;
    n_err     = m_err;
    if (!rst_n) begin
      {e_pc, e_ifid, e_fl, e_bub, e_frz} = 5'b01110;
      n_pending = 0;
      n_err     = 0;
    end else if (hif.mem_busy) begin
      {e_pc, e_ifid, e_fl, e_bub, e_frz} = 5'b00001;
      n_frz = (m_frz < 255) ? m_frz + 1 : m_frz;
      if (n_frz >= TO) n_err = 1;
    end else if (m_pending > 0) begin
      {e_pc, e_ifid, e_fl, e_bub, e_frz} = 5'b00010;
      n_pending = m_pending - 1;
    end else if (need > 0) begin
      {e_pc, e_ifid, e_fl, e_bub, e_frz} = 5'b00010;
      n_pending = need - 1;
    end else begin
      e_pc = 1; e_ifid = 1; e_bub = 0; e_frz = 0;
      e_fl = (hif.branch_ID && hif.branch_taken_ID) || hif.jump_ID;
    end
    cmp("PC_write",     {31'd0, hif.PC_write},     {31'd0, e_pc});
    cmp("IF_ID_write",  {31'd0, hif.IF_ID_write},  {31'd0, e_ifid});
    cmp("IF_Flush",     {31'd0, hif.IF_Flush},     {31'd0, e_fl});
    cmp("ID_EX_bubble", {31'd0, hif.ID_EX_bubble}, {31'd0, e_bub});
    cmp("pipe_freeze",  {31'd0, hif.pipe_freeze},  {31'd0, e_frz});
    cmp("timeout_err",  {31'd0, hif.timeout_err},  {31'd0, m_err});
`ifdef HAZARD_PERF_CNT_EN
    cmp("stall_cycles", hif.stall_cycles, m_stall);
    cmp("flush_count",  hif.flush_count,  m_flush);
    n_stall = rst_n ? m_stall + ((e_bub || e_frz) ? 1 : 0) : 0;
    n_flush = rst_n ? m_flush + (e_fl ? 1 : 0) : 0;
`endif
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pending <= 0; m_frz <= 0; m_err <= 0;
`ifdef HAZARD_PERF_CNT_EN
      m_stall <= 0; m_flush <= 0;
`endif
    end else begin
      m_pending <= n_pending; m_frz <= n_frz; m_err <= n_err;
`ifdef HAZARD_PERF_CNT_EN
      m_stall <= n_stall; m_flush <= n_flush;
`endif
    end
  end

  task automatic set_idle();
    hif.instruction_ID  = 32'd0;
    hif.branch_ID       = 1'b0;
    hif.branch_taken_ID = 1'b0;
    hif.jump_ID         = 1'b0;
    hif.ID_EX_MemRead   = 1'b0;
    hif.ID_EX_RegWrite  = 1'b0;
    hif.ID_EX_wreg      = 5'd0;
    hif.mem_busy        = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    hif.ID_EX_MemRead  = 1'b0;
    hif.ID_EX_RegWrite = 1'b0;
    hif.ID_EX_wreg     = 5'd0;
  endtask

  task automatic load_branch();
    hif.ID_EX_MemRead   = 1'b1;
    hif.ID_EX_RegWrite  = 1'b1;
    hif.ID_EX_wreg      = 5'd9;
    hif.branch_ID       = 1'b1;
    hif.branch_taken_ID = 1'b1;
    hif.instruction_ID  = 32'd9 << 16;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, want finish before 100000ns");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    set_idle();
    // 1. reset
    repeat (3) @(posedge clk);
    #1;
    cmp("rst PC_write",     {31'd0, hif.PC_write},     32'd0);
    cmp("rst IF_ID_write",  {31'd0, hif.IF_ID_write},  32'd1);
    cmp("rst IF_Flush",     {31'd0, hif.IF_Flush},     32'd1);
    cmp("rst ID_EX_bubble", {31'd0, hif.ID_EX_bubble}, 32'd1);
    cmp("rst timeout_err",  {31'd0, hif.timeout_err},  32'd0);
    rst_n = 1'b1;
    #1;
    cmp("run PC_write", {31'd0, hif.PC_write}, 32'd1);
    cmp("run IF_Flush", {31'd0, hif.IF_Flush}, 32'd0);

    // 2. load-use: one bubble
    tick();
    hif.ID_EX_MemRead = 1'b1; hif.ID_EX_RegWrite = 1'b1; hif.ID_EX_wreg = 5'd8;
    hif.instruction_ID = 32'd8 << 21;
    #1;
    cmp("lu bubble", {31'd0, hif.ID_EX_bubble}, 32'd1);
    cmp("lu PC_write", {31'd0, hif.PC_write}, 32'd0);
    tick();
    clear_ex();
    #1;
    cmp("lu after PC_write", {31'd0, hif.PC_write}, 32'd1);
    cmp("lu after bubble", {31'd0, hif.ID_EX_bubble}, 32'd0);

    // 3. load-branch: two bubbles, then the taken flush
    tick();
    load_branch();
    #1;
    cmp("lb b1 bubble", {31'd0, hif.ID_EX_bubble}, 32'd1);
    cmp("lb b1 flush",  {31'd0, hif.IF_Flush},     32'd0);
    tick();
    clear_ex();
    #1;
    cmp("lb b2 bubble", {31'd0, hif.ID_EX_bubble}, 32'd1);
    cmp("lb b2 flush",  {31'd0, hif.IF_Flush},     32'd0);
    tick();
    #1;
    cmp("lb flush",      {31'd0, hif.IF_Flush},     32'd1);
    cmp("lb IF_ID_write", {31'd0, hif.IF_ID_write}, 32'd1);
    set_idle();

    // 4. register 0 never hazards; jump flushes
    tick();
    hif.ID_EX_MemRead = 1'b1; hif.ID_EX_RegWrite = 1'b1;
    #1;
    cmp("r0 bubble", {31'd0, hif.ID_EX_bubble}, 32'd0);
    tick();
    set_idle();
    hif.jump_ID = 1'b1;
    #1;
    cmp("jmp flush",    {31'd0, hif.IF_Flush},    32'd1);
    cmp("jmp PC_write", {31'd0, hif.PC_write},    32'd1);
    tick();
    // branch operand produced by ALU op in EX: one bubble, not-taken branch has no flush
    set_idle();
    hif.branch_ID = 1'b1; hif.ID_EX_RegWrite = 1'b1; hif.ID_EX_wreg = 5'd5;
    hif.instruction_ID = 32'd5 << 21;
    #1;
    cmp("bh bubble", {31'd0, hif.ID_EX_bubble}, 32'd1);
    tick();
    clear_ex();
    #1;
    cmp("bh resume PC_write", {31'd0, hif.PC_write}, 32'd1);
    cmp("bh resume flush",    {31'd0, hif.IF_Flush}, 32'd0);
    set_idle();

    // 5. freeze during the second load-branch bubble
    tick();
    load_branch();
    tick();
    clear_ex();
    hif.mem_busy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      cmp("frz pipe_freeze", {31'd0, hif.pipe_freeze}, 32'd1);
      tick();
    end
    hif.mem_busy = 1'b0;
    #1;
    cmp("frz resume bubble", {31'd0, hif.ID_EX_bubble}, 32'd1);
    cmp("frz resume freeze", {31'd0, hif.pipe_freeze},  32'd0);
    tick();
    #1;
    cmp("frz done bubble", {31'd0, hif.ID_EX_bubble}, 32'd0);
    cmp("frz done flush",  {31'd0, hif.IF_Flush},     32'd1);
    cmp("frz no timeout",  {31'd0, hif.timeout_err},  32'd0);
    set_idle();

    // reset mid-stall aborts the pending bubble
    tick();
    load_branch();
    tick();
    set_idle();
    rst_n = 1'b0;
    #1;
    cmp("abort flush", {31'd0, hif.IF_Flush}, 32'd1);
    tick();
    rst_n = 1'b1;
    #1;
    cmp("abort PC_write", {31'd0, hif.PC_write},     32'd1);
    cmp("abort bubble",   {31'd0, hif.ID_EX_bubble}, 32'd0);

    // 6. watchdog: 10 freeze cycles with limit 5
    tick();
    hif.mem_busy = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      #1;
      cmp("wd timeout_err", {31'd0, hif.timeout_err}, (k >= 6) ? 32'd1 : 32'd0);
      tick();
    end
    hif.mem_busy = 1'b0;
    #1;
    cmp("wd sticky", {31'd0, hif.timeout_err}, 32'd1);
    tick();
    #1;
    cmp("wd sticky2", {31'd0, hif.timeout_err}, 32'd1);
    rst_n = 1'b0;
    #1;
    cmp("wd cleared", {31'd0, hif.timeout_err}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
